// File: rtl/hazard_stall_controller_pkg.sv
// Shared types for the pipeline hazard/stall sequencer: FSM states,
// default register-specifier width and the bundled stall-strobe vector.
package hazard_pkg;

  localparam int DEF_REG_ADDR_W = 5;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic hazard_signal_mux;
    logic pipe_freeze;
  } stall_vec_t;

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Hazard inputs from the pipeline stages and stall/flush strobes back to it.
// master = pipeline side, slave = the stall controller.
interface hazard_stall_controller_if
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int CNT_W      = 16
);
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rt;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic                  id_branch_taken;
  logic                  mem_req;
  logic                  mem_ready;
  logic                  pc_write;
  logic                  ifid_write;
  logic                  ifid_flush;
  logic                  hazard_signal_mux;
  logic                  pipe_freeze;
  logic [CNT_W-1:0]      stall_count;
  logic [CNT_W-1:0]      flush_count;
  logic                  timeout_err;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, id_branch_taken,
           mem_req, mem_ready,
    input  pc_write, ifid_write, ifid_flush, hazard_signal_mux, pipe_freeze,
           stall_count, flush_count, timeout_err
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, id_branch_taken,
           mem_req, mem_ready,
    output pc_write, ifid_write, ifid_flush, hazard_signal_mux, pipe_freeze,
           stall_count, flush_count, timeout_err
  );
endinterface

// File: rtl/hazard_stall_controller_sat_counter.sv
// Up-counter that holds at MAX instead of wrapping; synchronous clear
// takes priority over increment.
module sat_counter #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline stall/flush sequencer: memory freeze > load-use bubble > branch
// flush, all same-cycle, plus saturating perf counters and a timeout flag.
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  hazard_stall_controller_if.slave  bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state, state_next;
  stall_vec_t        sv;
  logic              mem_stall;
  logic              load_use;
  logic [WAIT_W-1:0] wait_count;
  logic              timeout_err;

  assign mem_stall = bus.mem_req & ~bus.mem_ready;
  assign load_use  = bus.ex_mem_read && (bus.ex_rt != '0) &&
                     ((bus.ex_rt == bus.id_rs) ||
                      (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    sv = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
           hazard_signal_mux: 1'b0, pipe_freeze: 1'b0};
    case (state)
      RUN:      if (mem_stall)  state_next = MEM_WAIT;
      MEM_WAIT: if (!mem_stall) state_next = RUN;
      default:  state_next = RUN;
    endcase

    // Frozen stages must not be altered, so no bubble or flush while held.
    if (rst) begin
      sv = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
             hazard_signal_mux: 1'b1, pipe_freeze: 1'b0};
    end else if (mem_stall) begin
      sv.pc_write    = 1'b0;
      sv.ifid_write  = 1'b0;
      sv.pipe_freeze = 1'b1;
    end else if (load_use) begin
      sv.pc_write          = 1'b0;
      sv.ifid_write        = 1'b0;
      sv.hazard_signal_mux = 1'b1;
    end else if (bus.id_branch_taken) begin
      sv.ifid_flush = 1'b1;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (~sv.pc_write),
    .count (bus.stall_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (sv.ifid_flush),
    .count (bus.flush_count)
  );

  sat_counter #(.WIDTH(WAIT_W), .MAX(WAIT_W'(MEM_TIMEOUT))) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_next == RUN),
    .inc   (state_next == MEM_WAIT),
    .count (wait_count)
  );

  // Sets on the edge at which the wait count reaches MEM_TIMEOUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else if ((state_next == MEM_WAIT) &&
                 (wait_count >= WAIT_W'(MEM_TIMEOUT - 1))) begin
      timeout_err <= 1'b1;
    end
  end

  assign bus.pc_write          = sv.pc_write;
  assign bus.ifid_write        = sv.ifid_write;
  assign bus.ifid_flush        = sv.ifid_flush;
  assign bus.hazard_signal_mux = sv.hazard_signal_mux;
  assign bus.pipe_freeze       = sv.pipe_freeze;
  assign bus.timeout_err       = timeout_err;

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Detects load-use hazards in ID.
- Freezes the pipeline while a multi-cycle data-memory access is outstanding.
- Flushes IF/ID on branches and jumps taken in ID.
- Drives hazard_signal_mux into the ID/EX control-bubble mux, plus PC and IF/ID write enables.
- Keeps saturating stall and flush performance counters and a sticky memory-timeout flag.

Parameters:
REG_ADDR_W, 5, register-specifier width.
CNT_W, 16, width of the stall and flush performance counters.
MEM_TIMEOUT, 64, number of consecutive MEM_WAIT cycles before timeout_err sets.

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous, active-high reset
id_rs  in  REG_ADDR_W  rs of the instruction in ID
id_rt  in  REG_ADDR_W  rt of the instruction in ID
id_uses_rt  in  1  the ID instruction reads rt as a source
ex_mem_read  in  1  the instruction in EX is a load
ex_rt  in  REG_ADDR_W  destination register of the load in EX
id_branch_taken  in  1  branch or jump resolved taken in ID
mem_req  in  1  the MEM stage has a load or store
mem_ready  in  1  data memory completes the access this cycle
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID register write enable
ifid_flush  out  1  clear IF/ID to a NOP
hazard_signal_mux  out  1  zero the ID/EX control fields (insert bubble)
pipe_freeze  out  1  hold the ID/EX, EX/MEM and MEM/WB registers
stall_count  out  CNT_W  cycles with pc_write=0
flush_count  out  CNT_W  number of ifid_flush pulses
timeout_err  out  1  sticky memory-timeout flag

Behaviour:
- States: RUN, MEM_WAIT. Outputs are combinational from state and inputs, so hazard response is same-cycle. The state register, wait counter and perf counters are registered.
- While rst=1:
  - pc_write=0, ifid_write=0, ifid_flush=0, hazard_signal_mux=1, pipe_freeze=0.
  - Counters=0, timeout_err=0, state=RUN.
- mem_stall = mem_req & ~mem_ready. This is highest priority.
  - pipe_freeze=1, pc_write=0, ifid_write=0.
  - hazard_signal_mux=0 and ifid_flush=0, because the held stages must not be altered.
- load_use = ex_mem_read & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)). It applies only when there is no mem_stall.
  - pc_write=0, ifid_write=0, hazard_signal_mux=1, ifid_flush=0.
  - Exactly one bubble per load; the following cycle the load has left EX.
- Branch flush: id_branch_taken with neither mem_stall nor load_use gives ifid_flush=1, pc_write=1, ifid_write=1.
  - A taken branch coincident with load_use is suppressed. ID is held, so the branch re-resolves next cycle and flushes then (flush_count +1 once).
- Otherwise: pc_write=1, ifid_write=1, all other strobes 0.
- Transitions:
  - RUN→MEM_WAIT when mem_stall.
  - MEM_WAIT stays while mem_stall.
  - MEM_WAIT→RUN in the cycle mem_ready=1. Freeze drops in that same cycle.
  - mem_req=1 with mem_ready=1 in RUN gives zero stall cycles.
- Wait counter:
  - Clears on entry to RUN and increments each MEM_WAIT cycle, saturating at MEM_TIMEOUT.
  - timeout_err sets when the count reaches MEM_TIMEOUT and stays set until rst.
  - The FSM does not abort the access; it remains in MEM_WAIT.
- Perf counters:
  - stall_count +1 each cycle with rst=0 and pc_write=0.
  - flush_count +1 each ifid_flush cycle.
  - Both saturate at all-ones; no wrap-around.
- Reset asserted mid-MEM_WAIT: immediate return to the reset values. After release, state=RUN regardless of mem_ready.

Decomposition:
- Package hazard_pkg holds:
  - the state enum (RUN, MEM_WAIT);
  - the REG_ADDR_W default;
  - a typedef for the stall-vector struct {pc_write, ifid_write, ifid_flush, hazard_signal_mux, pipe_freeze}.
- One sub-module, sat_counter, is a parameterised saturating up-counter with async active-high reset. It is instantiated twice for the perf counters and once for the wait counter.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 for 1 cycle → that cycle pc_write=0, ifid_write=0, hazard_signal_mux=1; next cycle all 0/1 normal; stall_count=1.
- ex_rt=0 with id_rs=0 and ex_mem_read=1 → no stall. id_rt match with id_uses_rt=0 → no stall.
- mem_req=1, mem_ready low for 3 cycles then high → pipe_freeze=1 for exactly 3 cycles with hazard_signal_mux=0; RUN reached on the ready cycle; stall_count=3.
- Load-use and id_branch_taken in the same cycle, then id_branch_taken held → cycle 1 bubble with no flush; cycle 2 ifid_flush=1; flush_count=1.
- mem_ready held low for MEM_TIMEOUT+5 cycles → timeout_err rises after 64 wait cycles and stays 1 after mem_ready. rst pulsed mid-wait → all outputs at reset values and timeout_err=0.
- Force stall for 2^CNT_W+3 cycles with CNT_W=4 → stall_count saturates at 15 and does not wrap.
